// File: rtl/dds_command_decoder.sv
// UART byte-stream command decoder driving a bank of DDS tuning words.
// Per-channel shadow loading, atomic SET, enables, readback and sticky error.
module dds_command_decoder #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      received,
    input  logic [7:0]                rx_byte,
    input  logic                      tx_busy,
    output logic                      transmit,
    output logic [7:0]                tx_byte,
    output logic [CHANNELS-1:0]       en,
    output logic [CHANNELS*WIDTH-1:0] m,
    output logic [CHANNELS-1:0]       set,
    output logic                      error
);

    localparam int BYTES = WIDTH / 8;
    localparam int SW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int LW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic {IDLE, DATA} state_e;

    state_e state_q, state_d;

    logic                            rx_q;
    logic [SW-1:0]                   sel_q, sel_d;
    logic [LW-1:0]                   lane_q, lane_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  shadow_q, shadow_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  m_q, m_d;
    logic [CHANNELS-1:0]             en_q, en_d;
    logic [CHANNELS-1:0]             set_q, set_d;
    logic                            err_q, err_d;
    logic                            txp_q, txp_d;
    logic [7:0]                      pend_q, pend_d;
    logic [7:0]                      txb_q, txb_d;
    logic                            xmit_q, xmit_d;

    logic       accept;
    logic [2:0] op;
    logic [4:0] arg;
    logic       ch_ok;
    logic       lane_ok;
    logic       bad;
    logic       good;
    logic       q_req;
    logic [7:0] q_byte;

    assign accept  = received & ~rx_q;
    assign op      = rx_byte[7:5];
    assign arg     = rx_byte[4:0];
    assign ch_ok   = {1'b0, arg} < 6'(CHANNELS);
    assign lane_ok = {1'b0, arg} < 6'(BYTES);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                IDLE: if (op == 3'b010 && lane_ok) state_d = DATA;
                DATA: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sel_d    = sel_q;
        lane_d   = lane_q;
        shadow_d = shadow_q;
        m_d      = m_q;
        en_d     = en_q;
        set_d    = '0;
        err_d    = err_q;
        txp_d    = txp_q;
        pend_d   = pend_q;
        txb_d    = txb_q;
        xmit_d   = 1'b0;
        bad      = 1'b0;
        good     = 1'b0;
        q_req    = 1'b0;
        q_byte   = 8'h00;

        if (txp_q && !tx_busy) begin
            xmit_d = 1'b1;
            txb_d  = pend_q;
            txp_d  = 1'b0;
        end

        if (accept && state_q == DATA)
            shadow_d[sel_q][{lane_q, 3'b000} +: 8] = rx_byte;

        if (accept && state_q == IDLE) begin
            unique case (op)
                3'b000: bad = 1'b1;
                3'b001: begin
                    if (ch_ok) begin
                        sel_d = arg[SW-1:0];
                        good  = 1'b1;
                    end else bad = 1'b1;
                end
                3'b010: begin
                    if (lane_ok) begin
                        lane_d = arg[LW-1:0];
                        good   = 1'b1;
                    end else bad = 1'b1;
                end
                3'b011: begin
                    m_d[sel_q]   = shadow_q[sel_q];
                    set_d[sel_q] = 1'b1;
                    good         = 1'b1;
                end
                3'b100: begin
                    en_d[sel_q] = 1'b1;
                    good        = 1'b1;
                end
                3'b101: begin
                    en_d[sel_q] = 1'b0;
                    good        = 1'b1;
                end
                3'b110: begin
                    if (lane_ok && !txp_q) begin
                        q_req  = 1'b1;
                        q_byte = m_q[sel_q][{arg[LW-1:0], 3'b000} +: 8];
                        good   = 1'b1;
                    end else bad = 1'b1;
                end
                3'b111: begin
                    if (!txp_q) begin
                        q_req  = 1'b1;
                        q_byte = {err_q, 2'b00, 5'(sel_q)};
                        good   = 1'b1;
                    end else bad = 1'b1;
                end
                default: bad = 1'b1;
            endcase
        end

        if (bad)       err_d = 1'b1;
        else if (good) err_d = 1'b0;

        // A queued byte only arrives when nothing is pending, so no clash above.
        if (q_req) begin
            if (!tx_busy) begin
                xmit_d = 1'b1;
                txb_d  = q_byte;
            end else begin
                txp_d  = 1'b1;
                pend_d = q_byte;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q     <= 1'b0;
            sel_q    <= '0;
            lane_q   <= '0;
            shadow_q <= '0;
            m_q      <= '0;
            en_q     <= '0;
            set_q    <= '0;
            err_q    <= 1'b0;
            txp_q    <= 1'b0;
            pend_q   <= 8'h00;
            txb_q    <= 8'h00;
            xmit_q   <= 1'b0;
        end else begin
            rx_q     <= received;
            sel_q    <= sel_d;
            lane_q   <= lane_d;
            shadow_q <= shadow_d;
            m_q      <= m_d;
            en_q     <= en_d;
            set_q    <= set_d;
            err_q    <= err_d;
            txp_q    <= txp_d;
            pend_q   <= pend_d;
            txb_q    <= txb_d;
            xmit_q   <= xmit_d;
        end
    end

    assign transmit = xmit_q;
    assign tx_byte  = txb_q;
    assign en       = en_q;
    assign m        = m_q;
    assign set      = set_q;
    assign error    = err_q;

endmodule

// File: doc/dds_command_decoder.md
Name: dds_command_decoder

Overview:
- Parametrised successor to the single-channel UART command decoder: one byte stream drives CHANNELS independent DDS tuning words of WIDTH bits each.
- Per-channel shadow loading, atomic SET, per-channel enable, readback over the UART transmitter, and a sticky error flag.
- Sits between the UART rx/tx pair and the bank of phase accumulators.

Parameters:
- CHANNELS, 4, number of DDS channels; 1..32.
- WIDTH, 32, tuning-word width in bits; multiple of 8, 8..256. Localparam BYTES = WIDTH/8.

Ports:
- clk  in  1  system clock (12 MHz).
- rst_n  in  1  asynchronous active-low reset.
- received  in  1  rx strobe from UART; a byte is accepted on its rising edge only.
- rx_byte  in  8  received byte; valid while received is high.
- tx_busy  in  1  UART transmitter busy; no transmit may be issued while high.
- transmit  out  1  one-cycle pulse requesting transmission of tx_byte.
- tx_byte  out  8  byte to transmit; held stable until the next transmit.
- en  out  CHANNELS  per-channel enable.
- m  out  CHANNELS*WIDTH  tuning words, flattened; channel c occupies [c*WIDTH +: WIDTH].
- set  out  CHANNELS  one-cycle pulse per channel when its m updates.
- error  out  1  sticky command error.

Behaviour:
- Reset (async, rst_n=0): transmit=0, tx_byte=0, en=0, m=0, set=0, error=0, all shadows=0, sel=0, tx_pending=0, state=IDLE. Reset mid-DATA discards the partial load.
- Byte acceptance: edge detector on received (registered copy). A received level held for multiple cycles is one byte. All outputs are registered and update the cycle after the accepted edge.
- Command byte = {op[7:5], arg[4:0]}:
  - 000: invalid; sets error.
  - 001 SELECT: sel<=arg. If arg>=CHANNELS, set error and leave sel unchanged.
  - 010 LOAD: if arg<BYTES, latch lane=arg and go to DATA; otherwise set error and stay in IDLE.
  - 011 SET: m[sel]<=shadow[sel]; set[sel]=1 for exactly one cycle.
  - 100 ENABLE: en[sel]<=1.
  - 101 DISABLE: en[sel]<=0.
  - 110 READ: if arg<BYTES, queue byte arg of m[sel], not shadow; otherwise set error.
  - 111 STATUS: queue {error, 2'b00, sel zero-extended to 5 bits}. The error value sent is the value before this command clears it.
  - arg is ignored for SET, ENABLE, DISABLE and STATUS.
- States:
  - IDLE: accepted byte is decoded as a command.
  - DATA: next accepted byte of any value is written to shadow[sel][lane*8 +: 8], then return to IDLE. DATA bytes never set or clear error.
- Error: sticky. Set on any invalid command. Cleared by the next valid command. If one command both sets and clears, set wins.
- Shadows are per channel: interleaved partial loads on different channels do not corrupt each other. m changes only on SET.
- Transmit path:
  - Queued byte goes to tx_byte with transmit=1 on the first cycle tx_busy=0. The earliest is the cycle after acceptance.
  - If tx_busy=1, hold tx_pending until free.
  - A READ or STATUS accepted while tx_pending=1 sets error and is dropped; the pending byte is unaffected.
- Simultaneous events: byte acceptance and a pending transmit in the same cycle are both serviced. At most one set bit is high in any cycle.

Test Plan (CHANNELS=4, WIDTH=32):
1. 0x22, then 0x40/0x2A, 0x41/0x67, 0x42/0x02, 0x43/0x00, then 0x60 -> m[2]=0x0002672A; set=4'b0100 for one cycle; m[0], m[1], m[3]=0; error=0 throughout.
2. After scenario 1: 0x80 -> en=4'b0100; 0x21, 0x80 -> en=4'b0110; 0xA0 -> en=4'b0100.
3. 0x00 -> error=1; 0x25 -> error stays 1 and sel unchanged; 0x60 -> error=0.
4. sel=2, tx_busy=0, 0xC1 -> one-cycle transmit, tx_byte=0x67. Repeat with tx_busy=1 for 20 cycles -> transmit is issued on the first cycle after tx_busy falls. A second 0xC0 sent during the busy window -> error=1 and still exactly one transmit.
5. Load lanes 0-1 of channel 1 (0x21, 0x40/0xAA, 0x41/0xBB), then 0x22, 0x40/0x11, then 0x21, 0x60 -> m[1]=0x0000BBAA; m[2] unchanged.
6. 0x40, then rst_n=0 for 3 cycles mid-DATA with the data byte pending -> all outputs 0. The next byte 0x60 is decoded as a command (SET, channel 0, set=4'b0001, m[0]=0).
